// File: rtl/onehot_strobe_decoder.sv
// Registered select-to-one-hot strobe decoder with pulse (PULSE_LEN cycles) and latch modes.
// Optional ONEHOT_DEC_ERR_EN build adds err / err_count for out-of-range selects.
module onehot_strobe_decoder #(
  parameter int SEL_W     = 4,
  parameter int NUM_OUT   = 16,
  parameter int PULSE_LEN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  input  logic               in_mode,
  output logic               in_ready,
  input  logic               clear,
  output logic [NUM_OUT-1:0] out_onehot,
  output logic               out_valid,
  output logic               busy
`ifdef ONEHOT_DEC_ERR_EN
  ,
  output logic               err,
  output logic [7:0]         err_count
`endif
);

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  localparam logic [7:0] CNT_INIT = 8'(PULSE_LEN - 1);

  state_t             state;
  logic [7:0]         cnt;
  logic               accept;
  logic [NUM_OUT-1:0] dec;

  // An out-of-range select simply matches no output bit, giving an all-zero strobe.
  always_comb begin
    dec = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      dec[k] = (in_sel == SEL_W'(k));
    end
  end

  assign in_ready = !clear && (state == IDLE || state == HOLD);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      out_onehot <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        out_onehot <= dec;
        out_valid  <= 1'b1;
        state      <= in_mode ? HOLD : PULSE;
        cnt        <= CNT_INIT;
      end else begin
        case (state)
          PULSE: begin
            if (cnt == 8'd0) begin
              state      <= IDLE;
              out_onehot <= '0;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          HOLD: begin
            if (clear) begin
              state      <= IDLE;
              out_onehot <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ONEHOT_DEC_ERR_EN
  logic bad_sel;
  assign bad_sel = ~|dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= accept && bad_sel;
      if (accept && bad_sel && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Drives a default instance and a NUM_OUT=12 / PULSE_LEN=3 instance against a cycle-count reference model.
module tb_onehot_strobe_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic        clear = 1'b0;

  logic        rdy0, vld0, bsy0, rdy1, vld1, bsy1;
  logic [15:0] oh0;
  logic [11:0] oh1;
  logic        err0, err1;
  logic [7:0]  ec0, ec1;

  always #5 clk = ~clk;

  onehot_strobe_decoder u0 (
    .clk(clk), .rst_n(rst_n), .in_sel(in_sel), .in_valid(in_valid), .in_mode(in_mode),
    .in_ready(rdy0), .clear(clear), .out_onehot(oh0), .out_valid(vld0), .busy(bsy0)
`ifdef ONEHOT_DEC_ERR_EN
    , .err(err0), .err_count(ec0)
`endif
  );

  onehot_strobe_decoder #(.NUM_OUT(12), .PULSE_LEN(3)) u1 (
    .clk(clk), .rst_n(rst_n), .in_sel(in_sel), .in_valid(in_valid), .in_mode(in_mode),
    .in_ready(rdy1), .clear(clear), .out_onehot(oh1), .out_valid(vld1), .busy(bsy1)
`ifdef ONEHOT_DEC_ERR_EN
    , .err(err1), .err_count(ec1)
`endif
  );

`ifndef ONEHOT_DEC_ERR_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
  assign ec0  = 8'd0;
  assign ec1  = 8'd0;
`endif

  // Reference model: remaining strobe cycles, latched flag, expected strobe value.
  int          n_out[2] = '{16, 12};
  int          p_len[2] = '{1, 3};
  int          pl[2];
  bit          hold[2];
  logic [15:0] val[2];
  bit          vf[2];
  bit          er[2];
  int          ecnt[2];

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] g_oh[2];
  logic        g_rdy[2], g_vld[2], g_bsy[2], g_err[2];
  logic [7:0]  g_ec[2];
  assign g_oh[0] = oh0;           assign g_oh[1] = {4'b0, oh1};
  assign g_rdy[0] = rdy0;         assign g_rdy[1] = rdy1;
  assign g_vld[0] = vld0;         assign g_vld[1] = vld1;
  assign g_bsy[0] = bsy0;         assign g_bsy[1] = bsy1;
  assign g_err[0] = err0;         assign g_err[1] = err1;
  assign g_ec[0] = ec0;           assign g_ec[1] = ec1;

  task automatic chk(input string tag, input int inst, input logic [31:0] got, input logic [31:0] exp);
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s u%0d: observed=%0h expected=%0h", tag, inst, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pl[i] = 0; hold[i] = 0; val[i] = '0; vf[i] = 0; er[i] = 0; ecnt[i] = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, ".onehot"}, i, {16'b0, g_oh[i]}, {16'b0, val[i]});
      chk({tag, ".valid"}, i, {31'b0, g_vld[i]}, {31'b0, vf[i]});
      chk({tag, ".busy"}, i, {31'b0, g_bsy[i]}, {31'b0, (pl[i] > 0 || hold[i])});
      chk({tag, ".onehot_cnt"}, i, {31'b0, ($countones(g_oh[i]) <= 1)}, 32'd1);
`ifdef ONEHOT_DEC_ERR_EN
      chk({tag, ".err"}, i, {31'b0, g_err[i]}, {31'b0, er[i]});
      chk({tag, ".err_count"}, i, {24'b0, g_ec[i]}, ecnt[i]);
`endif
    end
  endtask

  // One clock: drive inputs, check ready, advance model at the edge, check outputs.
  task automatic step(input bit v, input int s, input bit m, input bit c, input string tag);
    bit acc[2];
    in_valid = v; in_sel = 4'(s); in_mode = m; clear = c;
    #1;
    for (int i = 0; i < 2; i++) begin
      acc[i] = v && !c && (pl[i] == 0);
      chk({tag, ".ready"}, i, {31'b0, g_rdy[i]}, {31'b0, (!c && pl[i] == 0)});
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        val[i] = (s < n_out[i]) ? (16'(1) << s) : 16'h0;
        vf[i]  = 1;
        er[i]  = (s >= n_out[i]);
        if (er[i] && ecnt[i] < 255) ecnt[i]++;
        hold[i] = m;
        pl[i]   = m ? 0 : p_len[i];
      end else begin
        vf[i] = 0;
        er[i] = 0;
        if (pl[i] > 0) begin
          pl[i]--;
          if (pl[i] == 0) val[i] = '0;
        end else if (hold[i] && c) begin
          hold[i] = 0;
          val[i]  = '0;
        end
      end
    end
    #1;
    vectors++;
    check_outputs(tag);
  endtask

  initial begin
    model_reset();
    #2;
    check_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latch sel=5, then reset asynchronously between edges.
    step(1, 5, 1, 0, "latch5");
    step(0, 0, 0, 0, "hold5");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    check_outputs("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0, "post_rst");

    // Pulse-mode sweep of every select.
    for (int s = 0; s < 16; s++) begin
      step(1, s, 0, 0, "sweep");
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, "sweep_idle");
    end

    // Held valid during a pulse is only taken once the block is idle again.
    for (int k = 0; k < 6; k++) step(1, 9, 0, 0, "pulse9");
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, "pulse9_idle");

    // Replace a latched strobe without a gap.
    step(1, 2, 1, 0, "latch2");
    step(1, 7, 1, 0, "latch7");
    step(0, 0, 0, 0, "hold7");
    step(0, 0, 0, 1, "clear7");

    // Clear wins over a simultaneous command.
    step(1, 3, 1, 0, "latch3");
    step(1, 4, 0, 1, "clear_vs_cmd");
    step(1, 4, 0, 0, "cmd4");
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, "cmd4_idle");

    // Out-of-range select for the 12-output instance, repeated past saturation.
    for (int k = 0; k < 300; k++) step(1, 13, 1, 0, "oor");
    step(0, 0, 0, 1, "oor_clear");
    step(0, 0, 0, 0, "oor_idle");

    // Random traffic.
    for (int k = 0; k < 500; k++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 1) == 1,
           $urandom_range(0, 4) == 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
